uart_receive: RTL
=================

// Module: uart_receive
// PURPOSE
//   UART receiver (8N1, LSB first), the receive end of the `send` transmitter.
//   Oversamples the asynchronous UART_RX line with the system clock.
//   Recovers one byte per frame and flags framing errors.
//   Sits beside `send` at the board I/O boundary and feeds received bytes
//   to the CPU-side logic.
// PARAMETERS
//   wtime  10  clocks per bit period; same value as send's wtime; legal range >= 4
// PORTS
//   CLK      in   1  system clock; all logic on its rising edge
//   RESET    in   1  synchronous, active-low reset
//   UART_RX  in   1  serial input, asynchronous, idles high
//   data     out  8  last correctly received byte; held until the next good frame
//   valid    out  1  one-cycle pulse; data updated in this same cycle
//   ferr     out  1  one-cycle pulse; frame had stop bit = 0
//   busy     out  1  high while a frame is being received (START/DATA/STOP)
// BEHAVIOUR
//   - Sync: UART_RX passes through 2 flops (rx_s); both reset to 1.
//     rx_s is the only copy of the line the FSM uses.
//   - Reset (RESET==0 at a CLK edge):
//       state=WAIT_HIGH; data=8'h00; valid=0; ferr=0; busy=0;
//       bit counter=0; clock counter=0; shift register=0.
//     A frame in progress is discarded, with no valid and no ferr.
//   - States and transitions:
//       WAIT_HIGH: rx_s==1 -> IDLE.
//       IDLE:      rx_s==0 at cycle T -> START; clock counter cleared.
//       START:     count wtime/2 clocks (integer division), then sample at T+wtime/2.
//                  0 -> DATA. 1 -> IDLE (glitch: no outputs, busy drops).
//       DATA:      sample every wtime clocks, at T+wtime/2+k*wtime for k=1..8.
//                  Shift right: bit k lands in position k-1, so first bit = LSB.
//                  After k=8 -> STOP.
//       STOP:      sample at T+wtime/2+9*wtime.
//                  1 -> next cycle valid=1, data=shift, state IDLE.
//                  0 -> next cycle ferr=1, data unchanged, state WAIT_HIGH.
//   - Latency: valid/ferr asserted exactly at T+wtime/2+9*wtime+1.
//     Example: wtime=10 gives T+96.
//   - Back-to-back frames: a new start bit is accepted in the first IDLE cycle
//     after STOP. No extra gap is required beyond one full stop bit.
//   - The line is not checked between sample points; only centre samples count.
//   - valid and ferr are never high together; each is high for exactly 1 cycle.
//   - busy=1 exactly in START, DATA and STOP; busy=0 in IDLE and WAIT_HIGH.
//   - A break (line held low) gives one ferr pulse, then waits in WAIT_HIGH.
//     No repeated frames are reported while the line stays low.
// TESTING
//   1. send(wtime=10) transmits 8'h67 into UART_RX
//      -> single valid pulse at T+96, data=8'h67, ferr never 1.
//   2. Back-to-back 8'h00 then 8'hFF, one stop bit between them
//      -> two valid pulses 100 clocks apart, data 8'h00 then 8'hFF.
//   3. UART_RX low for 3 clocks, then high
//      -> busy high for about 5 clocks, no valid/ferr, FSM back in IDLE.
//   4. Frame 8'hA5 with stop bit forced 0 and line held low 30 more clocks
//      -> one ferr pulse, data keeps its prior value.
//      Line then released and 8'h3C sent -> valid, data=8'h3C.
//   5. RESET asserted during data bit 4 and released while the line is low
//      -> no valid/ferr for that frame.
//      The next full 8'h81 frame is received correctly.
//   6. wtime=7 (odd), frame 8'h5A
//      -> start sample at T+3, valid at T+67, data=8'h5A.

Source files
------------

// File: rtl/uart_receive.sv
// Purpose : 8N1 UART receiver (LSB first), oversampling UART_RX with CLK.
// Latency : valid/ferr pulse wtime/2 + 9*wtime + 1 cycles after the synchronised start edge.
// Backpr. : none; a byte is presented for one cycle on valid and must be taken then.
//
// Ports:
//   CLK     - system clock, rising edge
//   RESET   - synchronous, active-low reset
//   UART_RX - asynchronous serial input, idles high
//   data    - last correctly received byte, held until the next good frame
//   valid   - one-cycle pulse, data updated in the same cycle
//   ferr    - one-cycle pulse, frame ended with stop bit = 0
//   busy    - high while in START/DATA/STOP
module uart_receive #(
  parameter int wtime = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int HALF = wtime / 2;
  localparam int CW   = $clog2(wtime + 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            w_rx;

  // Second synchroniser stage is the only view of the line the FSM uses.
  assign w_rx = r_sync[1];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sync    <= 2'b11;
      r_state   <= WAIT_HIGH;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      ferr      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], UART_RX};
      valid  <= 1'b0;
      ferr   <= 1'b0;

      case (r_state)
        // After a framing error (or reset) the line must return high before
        // a new start edge is trusted; a held break reports only once.
        WAIT_HIGH: begin
          if (w_rx) r_state <= IDLE;
        end

        IDLE: begin
          if (!w_rx) begin
            r_state   <= START;
            r_clk_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        // Centre of the start bit: a high line here was a glitch.
        START: begin
          if (r_clk_cnt == CW'(HALF - 1)) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        // Shift right so the first bit received ends up as the LSB.
        DATA: begin
          if (r_clk_cnt == CW'(wtime - 1)) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state   <= STOP;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        // Returning straight to IDLE lets a back-to-back start bit be caught
        // right after a single stop bit.
        STOP: begin
          if (r_clk_cnt == CW'(wtime - 1)) begin
            r_clk_cnt <= '0;
            busy      <= 1'b0;
            if (w_rx) begin
              valid   <= 1'b1;
              data    <= r_shift;
              r_state <= IDLE;
            end else begin
              ferr    <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= WAIT_HIGH;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
